usb_bus_turnaround: RTL
=======================

Name: usb_bus_turnaround

Overview:
- Half-duplex bus sequencer for the USB full-speed PHY pair.
- Owns the receiver enable (rx_en) and grants the transmitter access to the shared dp/dn lines.
- Enforces the minimum inter-packet delay before any transmission.
- After a transmission that expects a reply, times out the response window and flags the timeout to the SIE.
- Sits between the SIE and the phy_rx/phy_tx pair. All sequencing advances on clk_gate_i, i.e. one step per full-speed bit time.

Parameters:
- BIT_SAMPLES, 4, clk_i cycles per bit time. Not used internally; documents the clk_gate_i ratio.
- IPD_BITS, 2, bit times the block waits after any received EOP or error before a tx grant is allowed; legal range 1..15.
- TIMEOUT_BITS, 18, bit times after tx_done_i within which a reply byte must arrive; legal range 2..63.

Ports:
- clk_i  in  1  clock, 12MHz*BIT_SAMPLES
- rstn_i  in  1  reset, asynchronous, active-low
- clk_gate_i  in  1  one-cycle strobe every BIT_SAMPLES clocks; all registers update only when high
- bus_reset_i  in  1  bus reset/detach indication from phy_rx
- rx_ready_i  in  1  phy_rx handshake strobe, one clk_gate period
- rx_valid_i  in  1  phy_rx data byte valid
- rx_err_i  in  1  phy_rx packet error
- rx_en_o  out  1  enable to phy_rx
- tx_req_i  in  1  SIE transmit request; level, held until granted
- expect_resp_i  in  1  sampled together with the grant; 1 = open a response window after the tx
- tx_grant_o  out  1  transmitter may drive the bus; held until tx_done_i
- tx_done_i  in  1  phy_tx end-of-EOP strobe, one clk_gate period
- rx_active_o  out  1  high while a received packet is in progress
- timeout_o  out  1  one clk_gate-period pulse on response timeout

Behaviour:
- Register update: only on clk_i edges with clk_gate_i=1. Inputs are sampled on the same edges. Outputs are registered.
- Reset values:
  - state=ST_IDLE, cnt=0
  - rx_en_o=0, tx_grant_o=0, rx_active_o=0, timeout_o=0, expect flag=0
- rx_en_o: 1 in IDLE, RX_PKT, RX_GAP and WAIT_RESP; 0 in TX and BUS_RST. It first rises on the first gate after reset.
- EOP definition: rx_ready_i=1 with rx_valid_i=0 and rx_err_i=0.
- States:
  - ST_IDLE:
    - rx_ready_i&rx_valid_i -> RX_PKT. Receive wins over a simultaneous tx_req_i.
    - Otherwise tx_req_i -> TX, with tx_grant_o=1 and expect latched from expect_resp_i.
  - ST_RX_PKT:
    - rx_active_o=1.
    - EOP or rx_err_i -> RX_GAP with cnt=0.
  - ST_RX_GAP:
    - cnt increments each gate; at cnt==IPD_BITS-1 -> IDLE.
    - A new rx byte here -> RX_PKT; tx_req_i is ignored here.
  - ST_TX:
    - tx_grant_o=1, rx_en_o=0.
    - tx_done_i -> tx_grant_o=0, cnt=0. Next state is WAIT_RESP if expect=1, else RX_GAP.
  - ST_WAIT_RESP:
    - cnt increments each gate.
    - rx byte -> RX_PKT.
    - rx_err_i or EOP -> RX_GAP.
    - cnt==TIMEOUT_BITS-1 with no rx_ready_i -> timeout_o=1 for one gate period, -> IDLE.
    - An rx byte on the timeout gate wins: no timeout is flagged.
  - ST_BUS_RST:
    - Entered from any state when bus_reset_i=1. Takes priority over every other transition, including mid-TX.
    - tx_grant_o=0, rx_en_o=0, rx_active_o=0, expect cleared, cnt=0.
    - Exits to IDLE on the first gate with bus_reset_i=0.
- cnt: 6 bits, saturating, never wraps. Cleared on every state entry.
- Illegal state encoding -> IDLE.
- tx_req_i dropped before grant: no grant is issued. tx_req_i deasserting during TX is ignored; only tx_done_i ends TX.
- tx_done_i outside TX: ignored.

Optional Feature:
- Macro: USB_TURNAROUND_STATS_EN.
- When defined, the block adds outputs timeout_cnt_o[7:0] and rx_err_cnt_o[7:0]:
  - Both are saturating counters at 255, reset to 0.
  - timeout_cnt_o increments on each timeout_o pulse.
  - rx_err_cnt_o increments on each rx_err_i&rx_ready_i.
  - Both clear when bus_reset_i=1.
- When undefined: no ports, no logic.

Test Plan:
- Reset, then idle 3 gates -> rx_en_o=1 from the first gate; tx_grant_o=0, timeout_o=0.
- Rx 3 bytes then EOP, with tx_req_i raised 1 gate after EOP and IPD_BITS=2 -> tx_grant_o rises exactly 3 gates after the EOP gate (2 gap gates + IDLE grant gate); rx_en_o falls on the same gate.
- Grant with expect_resp_i=1, tx_done_i, then no rx -> rx_en_o=1 on the next gate; timeout_o pulses exactly 18 gates after tx_done_i for one gate, then IDLE.
- Same as the previous case, but an rx byte arrives on gate 18 -> no timeout_o; rx_active_o=1 until EOP.
- bus_reset_i asserted mid-TX for 10 gates -> tx_grant_o=0 and rx_en_o=0 on the next gate; IDLE with rx_en_o=1 on the first gate after release.
- Simultaneous rx byte and tx_req_i in IDLE -> RX_PKT, no grant; grant issued after EOP + IPD.

Source files
------------

// File: rtl/usb_bus_turnaround.sv
// usb_bus_turnaround: half-duplex bus sequencer for the full-speed PHY pair.
// Owns rx_en_o, grants the transmitter after the inter-packet delay, and
// times out the response window after a transmission that expects a reply.
// Every register advances only on clk_gate_i (one step per bit time).
// Optional statistics counters: define USB_TURNAROUND_STATS_EN.
module usb_bus_turnaround #(
  parameter int BIT_SAMPLES  = 4,
  parameter int IPD_BITS     = 2,
  parameter int TIMEOUT_BITS = 18
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       clk_gate_i,
  input  logic       bus_reset_i,
  input  logic       rx_ready_i,
  input  logic       rx_valid_i,
  input  logic       rx_err_i,
  output logic       rx_en_o,
  input  logic       tx_req_i,
  input  logic       expect_resp_i,
  output logic       tx_grant_o,
  input  logic       tx_done_i,
  output logic       rx_active_o,
  output logic       timeout_o
`ifdef USB_TURNAROUND_STATS_EN
  ,
  output logic [7:0] timeout_cnt_o,
  output logic [7:0] rx_err_cnt_o
`endif
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RX_PKT    = 3'd1;
  localparam logic [2:0] ST_RX_GAP    = 3'd2;
  localparam logic [2:0] ST_TX        = 3'd3;
  localparam logic [2:0] ST_WAIT_RESP = 3'd4;
  localparam logic [2:0] ST_BUS_RST   = 3'd5;

  localparam logic [5:0] IPD_LAST = 6'(IPD_BITS - 1);
  localparam logic [5:0] TO_LAST  = 6'(TIMEOUT_BITS - 1);

  // Elaboration-time guard on the parameter ranges the counters can honour.
  if (BIT_SAMPLES < 1 || IPD_BITS < 1 || IPD_BITS > 15 ||
      TIMEOUT_BITS < 2 || TIMEOUT_BITS > 63) begin : g_param_err
    $error("usb_bus_turnaround: parameter out of range");
  end

  logic [2:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       expect_q, expect_d;
  logic       to_fire;
  logic       rx_byte, rx_eop;

  assign rx_byte = rx_ready_i & rx_valid_i & ~rx_err_i;
  assign rx_eop  = rx_ready_i & ~rx_valid_i & ~rx_err_i;

  // Next-state, counter and response-expect decision for the coming gate.
  always_comb begin
    state_d  = state_q;
    expect_d = expect_q;
    to_fire  = 1'b0;
    cnt_d    = (cnt_q == 6'h3f) ? cnt_q : cnt_q + 6'd1;
    if (bus_reset_i) begin
      state_d  = ST_BUS_RST;
      expect_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_ready_i & rx_valid_i) begin
            state_d = ST_RX_PKT;
          end else if (tx_req_i) begin
            state_d  = ST_TX;
            expect_d = expect_resp_i;
          end
        end
        ST_RX_PKT: begin
          if (rx_eop | rx_err_i) state_d = ST_RX_GAP;
        end
        ST_RX_GAP: begin
          if (rx_byte)                state_d = ST_RX_PKT;
          else if (cnt_q == IPD_LAST) state_d = ST_IDLE;
        end
        ST_TX: begin
          if (tx_done_i) state_d = expect_q ? ST_WAIT_RESP : ST_RX_GAP;
        end
        ST_WAIT_RESP: begin
          // A reply on the final gate of the window beats the timeout.
          if (rx_byte) begin
            state_d = ST_RX_PKT;
          end else if (rx_err_i | rx_eop) begin
            state_d = ST_RX_GAP;
          end else if (cnt_q == TO_LAST) begin
            state_d = ST_IDLE;
            to_fire = 1'b1;
          end
        end
        ST_BUS_RST: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
    // Counter restarts on every state entry and is idle outside timed states.
    if (state_d != state_q || state_d == ST_IDLE || state_d == ST_BUS_RST)
      cnt_d = 6'd0;
  end

  // State, counter and registered outputs decoded from the next state.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      expect_q    <= 1'b0;
      rx_en_o     <= 1'b0;
      tx_grant_o  <= 1'b0;
      rx_active_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else if (clk_gate_i) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      expect_q    <= expect_d;
      rx_en_o     <= (state_d == ST_IDLE) || (state_d == ST_RX_PKT) ||
                     (state_d == ST_RX_GAP) || (state_d == ST_WAIT_RESP);
      tx_grant_o  <= (state_d == ST_TX);
      rx_active_o <= (state_d == ST_RX_PKT);
      timeout_o   <= to_fire;
    end
  end

`ifdef USB_TURNAROUND_STATS_EN
  // Saturating timeout and receive-error counters, cleared by bus reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      timeout_cnt_o <= 8'd0;
      rx_err_cnt_o  <= 8'd0;
    end else if (clk_gate_i) begin
      if (bus_reset_i) begin
        timeout_cnt_o <= 8'd0;
        rx_err_cnt_o  <= 8'd0;
      end else begin
        if (to_fire && timeout_cnt_o != 8'hff)
          timeout_cnt_o <= timeout_cnt_o + 8'd1;
        if (rx_err_i && rx_ready_i && rx_err_cnt_o != 8'hff)
          rx_err_cnt_o <= rx_err_cnt_o + 8'd1;
      end
    end
  end
`endif

endmodule
